// File: rtl/axi_packetize_timeout.sv
// Packetizer that frames a continuous AXI-stream into packets of programmable length.
// The most recent word is held in a pending register so an idle timeout or flush can
// still close the open packet with a valid tlast.
module axi_packetize_timeout #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned MAX_PKT_SIZE     = 1024,
    parameter int unsigned SR_PKT_SIZE_ADDR = 1,
    parameter int unsigned SR_TIMEOUT_ADDR  = 2,
    parameter int unsigned TIMEOUT_WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             flush,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [15:0]      partial_cnt
);

    localparam int unsigned PW  = $clog2(MAX_PKT_SIZE + 1);
    localparam int unsigned TW  = TIMEOUT_WIDTH;
    localparam int unsigned TW1 = TIMEOUT_WIDTH + 1;
    localparam logic [PW-1:0] MaxSize = PW'(MAX_PKT_SIZE);
    localparam logic [PW-1:0] One     = PW'(1);

    logic [PW-1:0]    sr_pkt_size_q, sr_pkt_size_d;
    logic [TW-1:0]    sr_timeout_q, sr_timeout_d;
    logic [PW-1:0]    pkt_size_q, pkt_size_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             p_valid_q, p_valid_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             p_last_q, p_last_d;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             o_last_q, o_last_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             expired_q, expired_d;
    logic [15:0]      partial_cnt_q, partial_cnt_d;

    logic [PW-1:0]  size_sr, pos_acc, size_acc;
    logic [TW1-1:0] timer_inc;
    logic           o_free, idle, expired, close, p_move, accept, cut, new_last;

    // Clamp the programmed size into 1..MAX_PKT_SIZE.
    always_comb begin
        size_sr = sr_pkt_size_q;
        if (sr_pkt_size_q == '0) begin
            size_sr = One;
        end else if (sr_pkt_size_q > MaxSize) begin
            size_sr = MaxSize;
        end
    end

    // Transfer/accept decisions and next-state for settings, datapath and timer.
    always_comb begin
        o_free    = ~o_valid_q | o_tready;
        idle      = p_valid_q & ~p_last_q & ~i_tvalid & (sr_timeout_q != '0);
        timer_inc = {1'b0, timer_q} + TW1'(1);
        expired   = expired_q | (idle & (timer_inc >= {1'b0, sr_timeout_q}));
        close     = expired | flush;
        p_move    = o_free & p_valid_q & (p_last_q | i_tvalid | close);
        i_tready  = ~p_valid_q | p_move;
        accept    = i_tvalid & i_tready;
        // A short close ends the packet, so a word arriving on the same edge starts anew.
        cut       = p_move & ~p_last_q & close;
        pos_acc   = cut ? One : pos_q;
        size_acc  = (pos_acc == One) ? size_sr : pkt_size_q;
        new_last  = (pos_acc == size_acc) | i_tlast;

        sr_pkt_size_d = sr_pkt_size_q;
        sr_timeout_d  = sr_timeout_q;
        pkt_size_d    = pkt_size_q;
        pos_d         = pos_q;
        p_valid_d     = p_valid_q;
        p_data_d      = p_data_q;
        p_last_d      = p_last_q;
        o_valid_d     = o_valid_q;
        o_data_d      = o_data_q;
        o_last_d      = o_last_q;
        timer_d       = timer_q;
        expired_d     = expired_q;
        partial_cnt_d = partial_cnt_q;

        if (set_stb && (set_addr == 8'(SR_PKT_SIZE_ADDR))) begin
            sr_pkt_size_d = set_data[PW-1:0];
        end
        if (set_stb && (set_addr == 8'(SR_TIMEOUT_ADDR))) begin
            sr_timeout_d = set_data[TW-1:0];
        end

        if (p_move) begin
            o_valid_d = 1'b1;
            o_data_d  = p_data_q;
            o_last_d  = p_last_q | close;
            p_valid_d = 1'b0;
        end else if (o_tready) begin
            o_valid_d = 1'b0;
        end

        if (accept) begin
            p_valid_d = 1'b1;
            p_data_d  = i_tdata;
            p_last_d  = new_last;
            pos_d     = new_last ? One : pos_acc + One;
            if (pos_acc == One) begin
                pkt_size_d = size_sr;
            end
        end else if (cut) begin
            pos_d = One;
        end

        if (cut) begin
            partial_cnt_d = partial_cnt_q + 16'd1;
        end

        // Timer saturates once expired; only a transfer or an empty P releases it.
        if (p_move || !p_valid_q) begin
            timer_d   = '0;
            expired_d = 1'b0;
        end else if (i_tvalid) begin
            timer_d = '0;
        end else if (idle && !expired_q) begin
            timer_d = timer_inc[TW-1:0];
            if (timer_inc >= {1'b0, sr_timeout_q}) begin
                expired_d = 1'b1;
            end
        end

        if (clear) begin
            pkt_size_d    = size_sr;
            pos_d         = One;
            p_valid_d     = 1'b0;
            p_data_d      = '0;
            p_last_d      = 1'b0;
            o_valid_d     = 1'b0;
            o_data_d      = '0;
            o_last_d      = 1'b0;
            timer_d       = '0;
            expired_d     = 1'b0;
            partial_cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_pkt_size_q <= MaxSize;
            sr_timeout_q  <= '0;
            pkt_size_q    <= MaxSize;
            pos_q         <= One;
            p_valid_q     <= 1'b0;
            p_data_q      <= '0;
            p_last_q      <= 1'b0;
            o_valid_q     <= 1'b0;
            o_data_q      <= '0;
            o_last_q      <= 1'b0;
            timer_q       <= '0;
            expired_q     <= 1'b0;
            partial_cnt_q <= '0;
        end else begin
            sr_pkt_size_q <= sr_pkt_size_d;
            sr_timeout_q  <= sr_timeout_d;
            pkt_size_q    <= pkt_size_d;
            pos_q         <= pos_d;
            p_valid_q     <= p_valid_d;
            p_data_q      <= p_data_d;
            p_last_q      <= p_last_d;
            o_valid_q     <= o_valid_d;
            o_data_q      <= o_data_d;
            o_last_q      <= o_last_d;
            timer_q       <= timer_d;
            expired_q     <= expired_d;
            partial_cnt_q <= partial_cnt_d;
        end
    end

    assign o_tvalid    = o_valid_q;
    assign o_tdata     = o_data_q;
    assign o_tlast     = o_last_q;
    assign partial_cnt = partial_cnt_q;

endmodule

// File: tb/tb_axi_packetize_timeout.sv
// Self-checking bench for axi_packetize_timeout: cycle vectors plus directed sequences.
module tb_axi_packetize_timeout;

    localparam int unsigned MaxPkt = 8;
    localparam logic [7:0] AddrSize = 8'd1;
    localparam logic [7:0] AddrTo   = 8'd2;

    logic        clk, reset_n, clear, flush, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data, i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
    logic [15:0] partial_cnt;

    axi_packetize_timeout #(
        .WIDTH(32), .MAX_PKT_SIZE(MaxPkt), .SR_PKT_SIZE_ADDR(1), .SR_TIMEOUT_ADDR(2),
        .TIMEOUT_WIDTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .flush(flush), .set_stb(set_stb),
        .set_addr(set_addr), .set_data(set_data), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .partial_cnt(partial_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [31:0] td;
        logic        tl;
        logic        rdy;
        logic        fl;
        logic        e_it;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
        logic [15:0] e_pc;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    int checks = 0;
    int failures = 0;
    logic acc, ov_s;
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];

    function automatic vec_t mk(input logic tv, input logic [31:0] td, input logic tl,
                                input logic rdy, input logic fl, input logic eit,
                                input logic eov, input logic [31:0] eod, input logic eol,
                                input int epc);
        vec_t v;
        v.tv = tv; v.td = td; v.tl = tl; v.rdy = rdy; v.fl = fl;
        v.e_it = eit; v.e_ov = eov; v.e_od = eod; v.e_ol = eol; v.e_pc = 16'(epc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. Samples handshakes before the
    // rising edge and checks output stability across a stalled edge.
    task automatic cycle();
        logic stalled, sl;
        logic [31:0] sd;
        #2;
        acc  = i_tvalid & i_tready;
        ov_s = o_tvalid;
        if (o_tvalid && o_tready) out_q.push_back({o_tlast, o_tdata});
        stalled = o_tvalid & ~o_tready;
        sd = o_tdata;
        sl = o_tlast;
        @(negedge clk);
        if (stalled) begin
            chk("stall_valid", o_tvalid, 1);
            chk("stall_data", o_tdata, sd);
            chk("stall_last", o_tlast, sl);
        end
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        cycle();
        set_stb = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic send(input int n, input logic [31:0] base, input bit rnd, input int tl_at);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 300) begin
            i_tvalid = 1'b1;
            i_tdata  = base + 32'(idx);
            i_tlast  = (idx == tl_at);
            o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            if (acc) idx++;
            budget++;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        chk("send_accepted", idx, n);
    endtask

    task automatic drain(input int n, input bit rnd);
        int budget = 0;
        i_tvalid = 1'b0;
        while (out_q.size() < n && budget < 200) begin
            o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            budget++;
        end
        o_tready = 1'b1;
    endtask

    task automatic add_exp(input int n, input logic [31:0] base, input int pkt, input int off);
        for (int i = 0; i < n; i++) exp_q.push_back({1'(((i + off) % pkt) == pkt - 1),
                                                     base + 32'(i)});
    endtask

    task automatic compare_q(input string name);
        chk({name, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk($sformatf("%s_word%0d", name, i), out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc, first_ov, idx;
        reset_n = 1'b0; clear = 1'b0; flush = 1'b0; set_stb = 1'b0; set_addr = '0;
        set_data = '0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;

        vecs[0]  = mk(1, 'hA0, 0, 1, 0, 1, 0, 0,     0, 0);
        vecs[1]  = mk(1, 'hA1, 0, 1, 0, 1, 1, 'hA0, 0, 0);
        vecs[2]  = mk(1, 'hA2, 0, 1, 0, 1, 1, 'hA1, 0, 0);
        vecs[3]  = mk(1, 'hA3, 0, 1, 0, 1, 1, 'hA2, 0, 0);
        vecs[4]  = mk(0, 0,    0, 1, 0, 1, 1, 'hA3, 1, 0);
        vecs[5]  = mk(0, 0,    0, 1, 0, 1, 0, 0,     0, 0);
        vecs[6]  = mk(1, 'hB0, 0, 1, 0, 1, 0, 0,     0, 0);
        vecs[7]  = mk(0, 0,    0, 1, 0, 0, 0, 0,     0, 0);
        vecs[8]  = mk(0, 0,    0, 1, 0, 0, 0, 0,     0, 0);
        vecs[9]  = mk(0, 0,    0, 1, 0, 1, 1, 'hB0, 1, 1);
        vecs[10] = mk(0, 0,    0, 1, 0, 1, 0, 0,     0, 1);
        vecs[11] = mk(1, 'hC0, 0, 0, 0, 1, 0, 0,     0, 1);
        vecs[12] = mk(1, 'hC1, 0, 0, 0, 1, 1, 'hC0, 0, 1);
        vecs[13] = mk(1, 'hC2, 0, 0, 0, 0, 1, 'hC0, 0, 1);
        vecs[14] = mk(1, 'hC2, 0, 1, 0, 1, 1, 'hC1, 0, 1);
        vecs[15] = mk(0, 0,    0, 1, 1, 1, 1, 'hC2, 1, 2);
        vecs[16] = mk(1, 'hD0, 1, 1, 0, 1, 0, 0,     0, 2);
        vecs[17] = mk(0, 0,    0, 1, 0, 1, 1, 'hD0, 1, 2);
        vecs[18] = mk(0, 0,    0, 1, 1, 1, 0, 0,     0, 2);
        vecs[19] = mk(1, 'hE0, 0, 1, 0, 1, 0, 0,     0, 2);
        vecs[20] = mk(1, 'hE1, 0, 1, 1, 1, 1, 'hE0, 1, 3);
        vecs[21] = mk(1, 'hE2, 0, 1, 0, 1, 1, 'hE1, 0, 3);
        vecs[22] = mk(1, 'hE3, 0, 1, 0, 1, 1, 'hE2, 0, 3);
        vecs[23] = mk(1, 'hE4, 0, 1, 0, 1, 1, 'hE3, 0, 3);
        vecs[24] = mk(0, 0,    0, 1, 0, 1, 1, 'hE4, 1, 3);
        vecs[25] = mk(0, 0,    0, 1, 0, 1, 0, 0,     0, 3);

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_o_tvalid", o_tvalid, 0);
        chk("rst_o_tlast", o_tlast, 0);
        chk("rst_o_tdata", o_tdata, 0);
        chk("rst_partial_cnt", partial_cnt, 0);
        chk("rst_i_tready", i_tready, 1);
        @(negedge clk);

        // Cycle vectors: pkt_size 4, timeout 3.
        set_reg(AddrTo, 3);
        set_reg(AddrSize, 4);
        for (int i = 0; i < NV; i++) begin
            i_tvalid = vecs[i].tv; i_tdata = vecs[i].td; i_tlast = vecs[i].tl;
            o_tready = vecs[i].rdy; flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_i_tready", i), i_tready, vecs[i].e_it);
            cycle();
            chk($sformatf("v%0d_o_tvalid", i), o_tvalid, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_o_tdata", i), o_tdata, vecs[i].e_od);
                chk($sformatf("v%0d_o_tlast", i), o_tlast, vecs[i].e_ol);
            end
            chk($sformatf("v%0d_partial_cnt", i), partial_cnt, vecs[i].e_pc);
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; flush = 1'b0; o_tready = 1'b1;

        // Continuous 0..11 with pkt_size 4 and no timeout.
        set_reg(AddrTo, 0);
        do_clear();
        out_q.delete();
        first_acc = -1; first_ov = -1; idx = 0;
        for (int j = 0; j < 60 && out_q.size() < 12; j++) begin
            i_tvalid = (idx < 12);
            i_tdata  = 32'(idx);
            cycle();
            if (acc) begin
                if (first_acc < 0) first_acc = j;
                idx++;
            end
            if (ov_s && first_ov < 0) first_ov = j;
        end
        i_tvalid = 1'b0;
        chk("cont_latency", first_ov - first_acc, 2);
        add_exp(12, 0, 4, 0);
        compare_q("cont");

        // Idle timeout of 5 closes word 1 short.
        set_reg(AddrTo, 5);
        do_clear();
        out_q.delete();
        send(2, 'h200, 0, -1);
        repeat (4) cycle();
        chk("to_not_yet", o_tvalid, 0);
        cycle();
        chk("to_o_tvalid", o_tvalid, 1);
        chk("to_o_tdata", o_tdata, 'h201);
        chk("to_o_tlast", o_tlast, 1);
        chk("to_partial_cnt", partial_cnt, 1);
        send(4, 'h210, 0, -1);
        drain(6, 0);
        exp_q.push_back({1'b0, 32'h200});
        exp_q.push_back({1'b1, 32'h201});
        add_exp(4, 'h210, 4, 0);
        compare_q("timeout");

        // i_tlast at position 2 of 8.
        set_reg(AddrTo, 0);
        set_reg(AddrSize, 8);
        do_clear();
        out_q.delete();
        send(2, 'h300, 0, 1);
        send(8, 'h310, 0, -1);
        drain(10, 0);
        add_exp(2, 'h300, 2, 0);
        add_exp(8, 'h310, 8, 0);
        compare_q("itlast");
        chk("itlast_partial_cnt", partial_cnt, 0);

        // Size change mid-packet, size 0, then an oversize value that clamps to MaxPkt.
        set_reg(AddrSize, 4);
        do_clear();
        out_q.delete();
        send(2, 'h400, 0, -1);
        set_reg(AddrSize, 2);
        send(8, 'h402, 0, -1);
        drain(10, 0);
        add_exp(4, 'h400, 4, 0);
        add_exp(6, 'h404, 2, 0);
        compare_q("resize");
        set_reg(AddrSize, 0);
        send(3, 'h410, 0, -1);
        drain(3, 0);
        add_exp(3, 'h410, 1, 0);
        compare_q("size0");
        set_reg(AddrSize, 12);
        send(8, 'h420, 0, -1);
        drain(8, 0);
        add_exp(8, 'h420, 8, 0);
        compare_q("clamp");

        // Random backpressure with pkt_size 3, then a flush pulse on a pending word.
        set_reg(AddrSize, 3);
        do_clear();
        out_q.delete();
        send(12, 'h500, 1, -1);
        drain(12, 1);
        add_exp(12, 'h500, 3, 0);
        compare_q("random");
        send(1, 'h520, 0, -1);
        cycle();
        flush = 1'b1;
        repeat (2) cycle();
        flush = 1'b0;
        cycle();
        chk("flush_partial_cnt", partial_cnt, 1);
        exp_q.push_back({1'b1, 32'h520});
        compare_q("flush");

        // Clear mid-packet.
        send(2, 'h600, 0, -1);
        do_clear();
        chk("clr_o_tvalid", o_tvalid, 0);
        chk("clr_partial_cnt", partial_cnt, 0);
        out_q.delete();
        send(3, 'h610, 0, -1);
        drain(3, 0);
        add_exp(3, 'h610, 3, 0);
        compare_q("clear");

        // Asynchronous reset mid-packet; settings return to MaxPkt and no timeout.
        send(1, 'h700, 0, -1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("pre_rst_partial_cnt", partial_cnt, 1);
        send(2, 'h710, 0, -1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_o_tvalid", o_tvalid, 0);
        chk("arst_o_tlast", o_tlast, 0);
        chk("arst_partial_cnt", partial_cnt, 0);
        chk("arst_i_tready", i_tready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        out_q.delete();
        send(8, 'h720, 0, -1);
        drain(8, 0);
        add_exp(8, 'h720, 8, 0);
        compare_q("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_packetize_timeout.md
# axi_packetize_timeout

Upstream framing stage for `axi_drop_partial_packet`. It cuts a continuous AXI-stream sample stream into packets of a programmable length by generating `o_tlast`. It holds the most recent word so that an idle input, or an explicit flush, can still close a packet with a valid `tlast`. The partial packets produced this way are exactly what the downstream stage drops or releases.

## Interface
Parameters:
- `WIDTH`, 32, data width.
- `MAX_PKT_SIZE`, 1024, maximum packet length in words; must be ≥ 2.
- `SR_PKT_SIZE_ADDR`, 1, settings address of the packet-size register.
- `SR_TIMEOUT_ADDR`, 2, settings address of the idle-timeout register.
- `TIMEOUT_WIDTH`, 16, width of the timeout register and idle timer.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of all datapath state; settings are kept.
- `flush`  in  1  force-close the packet currently open.
- `set_stb`, `set_addr`[7:0], `set_data`[31:0]  in  settings bus.
- `i_tdata`  in  WIDTH  input data.
- `i_tlast`  in  1  end-of-burst; forces `tlast` on this word.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  WIDTH  output data.
- `o_tlast`  out  1  output last.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.
- `partial_cnt`  out  16  count of packets closed short by timeout or flush; wraps.

## Operation
- Settings registers are internal and asynchronously reset.
  - `sr_pkt_size` holds `set_data[$clog2(MAX_PKT_SIZE+1)-1:0]`; reset value `MAX_PKT_SIZE`.
  - `sr_timeout` holds `set_data[TIMEOUT_WIDTH-1:0]`; reset value 0.
  - A write takes effect the cycle after `set_stb`.
- Effective packet size `pkt_size` is loaded from `sr_pkt_size` only at a packet boundary (word position 1 pending) or on `clear`.
  - A value of 0 loads as 1.
  - Values above `MAX_PKT_SIZE` load as `MAX_PKT_SIZE`.
- Datapath has two registers:
  - Pending register P: `p_valid`, `p_data`, `p_last`.
  - Output register O: `o_tvalid`, `o_tdata`, `o_tlast`.
- Position counter `pos` runs 1..`pkt_size`.
  - An accepted word gets `p_last = (pos == pkt_size) | i_tlast`.
  - `pos` returns to 1 after any word that leaves with `tlast = 1`, otherwise increments.
- `o_free = ~o_tvalid | o_tready`.
- P transfers to O on a clock edge when `o_free & p_valid & (p_last | i_tvalid | expired | flush)`.
  - `o_tlast` is set to `p_last | expired | flush`.
  - If `i_tvalid` is high and `expired`/`flush` is not, the word leaves with `tlast = 0`.
- `i_tready = ~p_valid | p_move`, where `p_move` is the transfer condition above. The input word is captured into P on the same edge that P empties.
- Idle timer:
  - Counts each cycle with `p_valid & ~p_last & ~i_tvalid & sr_timeout != 0`.
  - Resets to 0 on any input beat, or when P empties.
  - `expired` sets when the timer reaches `sr_timeout`, and stays set until P transfers; the timer saturates meanwhile.
  - `sr_timeout == 0` disables the timeout.
- Simultaneous `expired`/`flush` and `i_tvalid`: P leaves with `tlast = 1`, and the incoming word is captured at `pos = 1` (start of a new packet).
- `partial_cnt` increments when P transfers with `~p_last & (expired | flush)`.
- `flush` with P empty or `p_last` set has no effect and is not counted.
- `clear` clears P, O, `pos`, timer, `expired` and `partial_cnt`, and reloads `pkt_size`. Words in flight are discarded.

## Timing
- Reset values:
  - `o_tvalid`, `o_tlast`, `o_tdata` = 0.
  - `partial_cnt` = 0.
  - `i_tready` = 1 (combinational from `p_valid = 0`).
  - `pos` = 1.
- Latency:
  - Word with `p_last` known at acceptance: accepted at edge k, in P after k, `o_tvalid` after edge k+1 (2 cycles).
  - Otherwise the word stays in P until the next input beat, `flush`, or expiry.
- Timeout T: P leaves on the edge ending the T-th consecutive idle cycle if `o_free`; otherwise it leaves on the first edge with `o_free`.
- Sustained throughput is 1 word/cycle with `o_tready` held high.
- `o_tdata`/`o_tlast` are stable while `o_tvalid & ~o_tready`.
- `reset_n` asserted mid-packet clears everything immediately, without waiting for a clock. The first word after release is position 1.

## Test plan
- pkt_size 4, timeout 0, continuous input 0..11, `o_tready` = 1 → three packets, `o_tlast` on 3, 7, 11; first `o_tvalid` 2 cycles after the first accept.
- pkt_size 4, timeout 5, send 0,1 then idle → word 1 is output with `tlast = 1` 5 idle cycles later; `partial_cnt` = 1; the next word starts at position 1.
- Word with `i_tlast = 1` at position 2 of 8 → `tlast` on that word; `partial_cnt` unchanged; next packet is 8 words.
- Write pkt_size 2 mid-packet of size 4 → the current packet completes at 4 words; subsequent packets are 2 words. A write of 0 yields single-word packets, each with `tlast`.
- Random `o_tready` (50%) with pkt_size 3 → no data loss or duplication; outputs hold stable while stalled; `flush` pulse mid-packet closes it and `partial_cnt` increments once.
- `clear` and `reset_n` pulsed mid-packet → `o_tvalid` = 0 and `partial_cnt` = 0 next cycle; the next packet is a full `pkt_size` words.
